// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among NREQ requesters.
// Grants are held for a whole burst, and a watchdog reclaims the bus from stalled transfers or bursts.
module spi_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_err,
    output logic              m_start,
    output logic [7:0]        m_tx_data,
    input  logic              m_done,
    input  logic [7:0]        m_rx_data
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      r_state;
    logic [TW-1:0]   r_timer;
    logic [IDXW-1:0] r_rrPtr;
    logic            r_last;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_rspValid;
    logic [7:0]      r_rspData;
    logic            r_busy;
    logic            r_timeoutErr;
    logic            r_mStart;
    logic [7:0]      r_mTxData;

    logic            w_anyValid;
    logic [IDXW-1:0] w_pickIdx;
    logic [IDXW-1:0] w_scanIdx;
    logic [NREQ-1:0] w_pickOneHot;
    logic            w_handshake;
    logic            w_timerExpired;

    // Scan from rr_ptr+1 backwards through the loop so the earliest valid index in rotation order wins.
    always_comb begin
        w_anyValid = 1'b0;
        w_pickIdx  = '0;
        w_scanIdx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scanIdx = IDXW'((int'(r_rrPtr) + 1 + k) % NREQ);
            if (req_valid[w_scanIdx]) begin
                w_anyValid = 1'b1;
                w_pickIdx  = w_scanIdx;
            end
        end
    end

    assign w_pickOneHot   = {{(NREQ-1){1'b0}}, 1'b1} << w_pickIdx;
    assign w_handshake    = |(req_valid & r_grant);
    assign w_timerExpired = (r_timer == TIMER_MAX);

    // While granted, rr_ptr doubles as the owner's index for muxing its data and last flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_rrPtr      <= IDXW'(NREQ - 1);
            r_last       <= 1'b0;
            r_grant      <= '0;
            r_rspValid   <= '0;
            r_rspData    <= 8'h00;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_mStart     <= 1'b0;
            r_mTxData    <= 8'h00;
        end else begin
            r_mStart     <= 1'b0;
            r_rspValid   <= '0;
            r_timeoutErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyValid) begin
                        r_grant <= w_pickOneHot;
                        r_rrPtr <= w_pickIdx;
                        r_timer <= '0;
                        r_state <= S_ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_handshake) begin
                        r_mTxData <= req_data[{r_rrPtr, 3'b000} +: 8];
                        r_last    <= req_last[r_rrPtr];
                        r_mStart  <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= S_WAIT;
                    end else if (w_timerExpired) begin
                        r_timeoutErr <= 1'b1;
                        r_grant      <= '0;
                        r_timer      <= '0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A done still asserted from the previous byte overlaps the start pulse and must not count.
                    if (m_done && !r_mStart) begin
                        r_rspData  <= m_rx_data;
                        r_rspValid <= r_grant;
                        r_state    <= S_RESP;
                    end else if (w_timerExpired) begin
                        r_timeoutErr <= 1'b1;
                        r_grant      <= '0;
                        r_timer      <= '0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    if (r_last) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= '0;
                        r_state <= S_ISSUE;
                    end
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_ISSUE) ? r_grant : '0;
    assign rsp_valid   = r_rspValid;
    assign rsp_data    = r_rspData;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeoutErr;
    assign m_start     = r_mStart;
    assign m_tx_data   = r_mTxData;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a small SPI slave model that answers tx ^ 8'h99.
// Expected bytes: A5->3C, 5A->C3, C3->5A, 0F->96, F0->69, 11->88, 22->BB, 33->AA, 77->EE, 44->DD, 55->CC.
module tb_spi_master_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  reqValid = '0;
    logic [15:0] reqData = '0;
    logic [1:0]  reqLast = '0;
    logic [1:0]  reqReady;
    logic [1:0]  rspValid;
    logic [7:0]  rspData;
    logic [1:0]  grant;
    logic        busy;
    logic        timeoutErr;
    logic        mStart;
    logic [7:0]  mTxData;
    logic        mDone = 1'b0;
    logic [7:0]  mRxData = '0;

    bit slaveOn = 1'b1;
    int startCount = 0;
    int checkCount = 0;
    int passCount = 0;

    spi_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_data(reqData), .req_last(reqLast), .req_ready(reqReady),
        .rsp_valid(rspValid), .rsp_data(rspData), .grant(grant), .busy(busy),
        .timeout_err(timeoutErr), .m_start(mStart), .m_tx_data(mTxData),
        .m_done(mDone), .m_rx_data(mRxData)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (mStart) startCount++;
        end
    end

    // Slave answers two cycles after it sees the start pulse; it shares the arbiter's reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && slaveOn && mStart) begin
                repeat (2) @(negedge clk);
                if (reset) begin
                    mDone = 1'b1;
                    mRxData = mTxData ^ 8'h99;
                    @(negedge clk);
                    mDone = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
        reqData[idx*8 +: 8] = data;
        reqLast[idx] = last;
        reqValid[idx] = 1'b1;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic handshake(input string tag, input int idx);
        int waited = 0;
        while (!reqReady[idx] && waited < 4 * TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!reqReady[idx]) checkOutput({tag, "_ready"}, 32'd0, 32'd1);
        else @(negedge clk);
        reqValid[idx] = 1'b0;
    endtask

    task automatic expectRsp(input string tag, input logic [1:0] expValid, input logic [7:0] expData);
        int waited = 0;
        while (rspValid == 2'b00 && waited < 4 * TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_rspValid"}, rspValid, expValid);
        checkOutput({tag, "_rspData"}, rspData, expData);
    endtask

    task automatic waitGrant(input string tag, input logic [1:0] expGrant);
        int waited = 0;
        @(negedge clk);
        while (grant == 2'b00 && waited < 4 * TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(tag, grant, expGrant);
    endtask

    task automatic runSingle(input string tag);
        int startBefore = startCount;
        applyStimulus(0, 8'hA5, 1'b1);
        waitGrant({tag, "_grant"}, 2'b01);
        handshake(tag, 0);
        checkOutput({tag, "_mStart"}, mStart, 1);
        checkOutput({tag, "_txData"}, mTxData, 8'hA5);
        expectRsp(tag, 2'b01, 8'h3C);
        @(negedge clk);
        checkOutput({tag, "_rspPulse"}, rspValid, 2'b00);
        checkOutput({tag, "_grantIdle"}, grant, 2'b00);
        checkOutput({tag, "_busyIdle"}, busy, 0);
        checkOutput({tag, "_startCount"}, startCount - startBefore, 1);
    endtask

    initial begin
        int cycles;
        bit sawFlag;

        repeat (3) @(negedge clk);
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rspValid", rspValid, 2'b00);
        checkOutput("rst_mStart", mStart, 0);
        checkOutput("rst_timeoutErr", timeoutErr, 0);
        checkOutput("rst_rspData", rspData, 8'h00);
        checkOutput("rst_txData", mTxData, 8'h00);
        checkOutput("rst_reqReady", reqReady, 2'b00);
        reset = 1'b1;

        runSingle("t1");

        // Simultaneous requests after reset, then a second round to show rotation
        applyReset();
        applyStimulus(0, 8'h5A, 1'b1);
        applyStimulus(1, 8'hC3, 1'b1);
        waitGrant("t2_first", 2'b01);
        handshake("t2a", 0);
        expectRsp("t2a", 2'b01, 8'hC3);
        waitGrant("t2_second", 2'b10);
        handshake("t2b", 1);
        expectRsp("t2b", 2'b10, 8'h5A);
        applyStimulus(0, 8'h0F, 1'b1);
        applyStimulus(1, 8'hF0, 1'b1);
        waitGrant("t2_rotate", 2'b01);
        handshake("t2c", 0);
        expectRsp("t2c", 2'b01, 8'h96);
        waitGrant("t2_rotate2", 2'b10);
        handshake("t2d", 1);
        expectRsp("t2d", 2'b10, 8'h69);

        // Three-byte burst from req1 while req0 waits
        applyStimulus(1, 8'h11, 1'b0);
        waitGrant("t3_grant", 2'b10);
        applyStimulus(0, 8'h77, 1'b1);
        handshake("t3b1", 1);
        expectRsp("t3b1", 2'b10, 8'h88);
        checkOutput("t3b1_hold", grant, 2'b10);
        applyStimulus(1, 8'h22, 1'b0);
        handshake("t3b2", 1);
        expectRsp("t3b2", 2'b10, 8'hBB);
        checkOutput("t3b2_hold", grant, 2'b10);
        applyStimulus(1, 8'h33, 1'b1);
        handshake("t3b3", 1);
        expectRsp("t3b3", 2'b10, 8'hAA);
        checkOutput("t3b3_hold", grant, 2'b10);
        waitGrant("t3_req0", 2'b01);
        handshake("t3r0", 0);
        expectRsp("t3r0", 2'b01, 8'hEE);

        // Engine never completes: watchdog in WAIT
        slaveOn = 1'b0;
        applyStimulus(0, 8'hA0, 1'b1);
        waitGrant("t4_grant", 2'b01);
        handshake("t4", 0);
        cycles = 0;
        sawFlag = 1'b0;
        while (!timeoutErr && cycles < 4 * TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (rspValid != 2'b00) sawFlag = 1'b1;
        end
        checkOutput("t4_cycles", cycles, TIMEOUT);
        checkOutput("t4_noRsp", sawFlag, 0);
        checkOutput("t4_grant", grant, 2'b00);
        checkOutput("t4_busy", busy, 0);
        @(negedge clk);
        checkOutput("t4_errPulse", timeoutErr, 0);
        slaveOn = 1'b1;

        // Burst abandoned mid-way: watchdog in ISSUE, then the waiting requester is served
        applyStimulus(1, 8'h44, 1'b0);
        waitGrant("t5_grant", 2'b10);
        applyStimulus(0, 8'h55, 1'b1);
        handshake("t5", 1);
        expectRsp("t5", 2'b10, 8'hDD);
        cycles = 0;
        sawFlag = 1'b0;
        while (!timeoutErr && cycles < 4 * TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (reqReady[0]) sawFlag = 1'b1;
        end
        checkOutput("t5_cycles", cycles, TIMEOUT + 1);
        checkOutput("t5_noReady0", sawFlag, 0);
        checkOutput("t5_grantDrop", grant, 2'b00);
        waitGrant("t5_req0", 2'b01);
        handshake("t5r0", 0);
        expectRsp("t5r0", 2'b01, 8'hCC);

        // Asynchronous reset during WAIT
        applyStimulus(0, 8'hA5, 1'b1);
        waitGrant("t6_grant", 2'b01);
        handshake("t6", 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_grant", grant, 2'b00);
        checkOutput("t6_txData", mTxData, 8'h00);
        checkOutput("t6_rspData", rspData, 8'h00);
        checkOutput("t6_reqReady", reqReady, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("t6_noRsp", rspValid, 2'b00);
        reset = 1'b1;
        runSingle("t6r");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
